// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial N-bit adder, LSB-first, one full-adder cell plus carry flip-flop
// Start/busy/done handshake; sum/cout hold the last completed result.

module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);
endmodule

module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (WIDTH > 1) ? WIDTH - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [PW-1:0]    r_part;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic             w_load;
  logic [PW-1:0]    w_part_next;
  logic [WIDTH-1:0] w_sum_next;

  fa_cell u_fa (
    .i_a  (r_sa[0]),
    .i_b  (r_sb[0]),
    .i_ci (r_c),
    .o_s  (w_s),
    .o_co (w_c)
  );

  // The partial register only needs WIDTH-1 bits: the MSB of the result is the
  // sum bit produced on the completion edge itself.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_part_next = r_part;
      assign w_sum_next  = w_s;
    end else if (WIDTH == 2) begin : g_w2
      assign w_part_next = w_s;
      assign w_sum_next  = {w_s, r_part};
    end else begin : g_wn
      assign w_part_next = {w_s, r_part[PW-1:1]};
      assign w_sum_next  = {w_s, r_part};
    end
  endgenerate

  assign w_load = start && (r_state == S_IDLE || r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_part  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_c    <= w_c;
          r_sa   <= r_sa >> 1;
          r_sb   <= r_sb >> 1;
          r_part <= w_part_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_c;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (w_load) begin
            r_sa    <= a;
            r_sb    <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - directed and randomized bench for serial_adder_n at WIDTH 1, 8 and 13
module tb_serial_adder_n;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic        a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic [12:0] a13 = '0, b13 = '0;
  logic        cin13 = 1'b0;
  logic        busy8, done8, cout8, busy1, done1, cout1, busy13, done13, cout13;
  logic [7:0]  sum8;
  logic        sum1;
  logic [12:0] sum13;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder_n #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
  serial_adder_n #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch an add on the 8-bit instance and return in the done cycle.
  task automatic do_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input string tag);
    int n, nbusy, nunstable;
    logic [7:0] prev_sum;
    logic       prev_cout;
    prev_sum = sum8;
    prev_cout = cout8;
    a8 = ta; b8 = tb; cin8 = tc; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; nbusy = 0; nunstable = 0;
    while (!done8 && n < 40) begin
      if (busy8) nbusy++;
      if (sum8 !== prev_sum || cout8 !== prev_cout) nunstable++;
      tick();
      n++;
    end
    check({tag, " latency"}, n, 8);
    check({tag, " busy cycles"}, nbusy, 8);
    check({tag, " sum stable in run"}, nunstable, 0);
    check({tag, " busy in done"}, busy8, 0);
    check({tag, " sum"}, sum8, es);
    check({tag, " cout"}, cout8, ec);
  endtask

  initial begin
    int ndone;
    logic [7:0] cap;

    tick();
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset sum", sum8, 0);
    check("reset cout", cout8, 0);
    rst_n = 1'b1;
    tick();

    do_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add 5a+3c");
    tick();
    check("5a+3c done one pulse", done8, 0);

    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add ff+01");
    tick();
    check("ff+01 back to idle", {busy8, done8}, 0);

    do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add ff+ff+1");
    do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "b2b 0+0");
    tick();
    check("b2b done one pulse", done8, 0);

    // start re-pulsed mid-run must be ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a8 = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0; a8 = 8'h00;
    ndone = 0; cap = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin ndone++; cap = sum8; end
      tick();
    end
    check("repulse done count", ndone, 1);
    check("repulse sum", cap, 8'h30);
    check("repulse cout", cout8, 0);

    // reset in the middle of a run
    a8 = 8'h5A; b8 = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("pre-abort busy", busy8, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort sum", sum8, 0);
    check("abort cout", cout8, 0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) ndone++;
      tick();
    end
    check("abort no done", ndone, 0);

    do_add(8'h07, ~8'h09, 1'b1, 8'hFE, 1'b0, "sub 07-09");
    tick();
    do_add(8'h09, ~8'h07, 1'b1, 8'h02, 1'b1, "sub 09-07");
    tick();

    // random operands against a golden a+b+cin across three widths
    for (int it = 0; it < 334; it++) begin
      logic [12:0] ra, rb;
      logic        rc;
      int d1, d8, d13, l1, l8, l13;
      logic [31:0] g1, g8, g13, e1, e8, e13;
      ra = 13'($urandom); rb = 13'($urandom); rc = 1'($urandom);
      a13 = ra; b13 = rb; cin13 = rc;
      a8 = ra[7:0]; b8 = rb[7:0]; cin8 = rc;
      a1 = ra[0]; b1 = rb[0]; cin1 = rc;
      e13 = 32'(ra) + 32'(rb) + 32'(rc);
      e8 = 32'(ra[7:0]) + 32'(rb[7:0]) + 32'(rc);
      e1 = 32'(ra[0]) + 32'(rb[0]) + 32'(rc);
      start = 1'b1;
      tick();
      start = 1'b0;
      d1 = 0; d8 = 0; d13 = 0; l1 = 0; l8 = 0; l13 = 0;
      g1 = '0; g8 = '0; g13 = '0;
      for (int n = 1; n <= 16; n++) begin
        tick();
        if (done1) begin d1++; l1 = n; g1 = {30'd0, cout1, sum1}; end
        if (done8) begin d8++; l8 = n; g8 = {23'd0, cout8, sum8}; end
        if (done13) begin d13++; l13 = n; g13 = {18'd0, cout13, sum13}; end
      end
      check("rnd w1 result", g1, e1);
      check("rnd w8 result", g8, e8);
      check("rnd w13 result", g13, e13);
      check("rnd done pulses", {d1[7:0], d8[7:0], d13[7:0]}, 32'h010101);
      check("rnd latencies", {l1[7:0], l8[7:0], l13[7:0]}, 32'h01080D);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
